// File: rtl/exec_dispatch_pkg.sv
// Shared types for the exec issue controller: context width, FSM encoding
// and the flush context-match helper.
package exec_dispatch_pkg;

  localparam int LEN_CONTEXT = 3;

  typedef enum logic [1:0] {
    DSP_IDLE  = 2'd0,
    DSP_ORDER = 2'd1,
    DSP_WAIT  = 2'd2
  } dsp_state_e;

  function automatic logic ctx_hit(input logic                   flush,
                                   input logic [LEN_CONTEXT-1:0] ctx_a,
                                   input logic [LEN_CONTEXT-1:0] ctx_b);
    return flush && (ctx_a == ctx_b);
  endfunction

endpackage

// File: rtl/exec_dispatch_rr_pick.sv
// Combinational round-robin picker: first set bit of mask scanning from
// ptr+1 upwards, wrapping modulo N_SLOT.
module rr_pick #(
  parameter int N_SLOT = 4
) (
  input  logic [N_SLOT-1:0]         mask,
  input  logic [$clog2(N_SLOT)-1:0] ptr,
  output logic                      found,
  output logic [$clog2(N_SLOT)-1:0] idx
);

  localparam int IW = $clog2(N_SLOT);

  logic [IW-1:0] cand;

  // Scan farthest-first so the nearest eligible slot after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int i = N_SLOT; i >= 1; i--) begin
      cand = ptr + IW'(i);
      if (mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/exec_dispatch.sv
// Issue controller between the instruction window and exec: round-robin
// slot selection, order/accepted/done handshake, one instruction in flight.
module exec_dispatch
  import exec_dispatch_pkg::*;
#(
  parameter int N_SLOT    = 4,
  parameter int W_PAYLOAD = 128
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_SLOT-1:0]             req,
  input  logic [N_SLOT*W_PAYLOAD-1:0]   req_payload,
  input  logic [N_SLOT*LEN_CONTEXT-1:0] req_context,
  output logic [N_SLOT-1:0]             grant,
  output logic                          exec_order,
  output logic [W_PAYLOAD-1:0]          exec_payload,
  output logic [LEN_CONTEXT-1:0]        exec_context,
  input  logic                          exec_accepted,
  input  logic                          exec_done,
  input  logic                          flush,
  input  logic [LEN_CONTEXT-1:0]        flush_context,
  output logic                          wb_valid,
  output logic                          busy,
  output logic [15:0]                   n_issued
);

  localparam int IW = $clog2(N_SLOT);

  dsp_state_e             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          sel_idx_q, sel_idx_d;
  logic [W_PAYLOAD-1:0]   sel_payload_q, sel_payload_d;
  logic [LEN_CONTEXT-1:0] sel_context_q, sel_context_d;
  logic                   discard_q, discard_d;
  logic [15:0]            n_issued_q, n_issued_d;

  logic [N_SLOT-1:0]      elig;
  logic                   pick_found;
  logic [IW-1:0]          pick_idx;
  logic                   kill;

  // Slots whose context is being flushed this cycle are not eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      elig[i] = req[i] & ~ctx_hit(flush, req_context[i*LEN_CONTEXT +: LEN_CONTEXT], flush_context);
    end
  end

  rr_pick #(.N_SLOT(N_SLOT)) u_pick (
    .mask  (elig),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign kill = ctx_hit(flush, flush_context, sel_context_q);

  // Next-state logic plus the combinational grant / wb_valid pulses.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    sel_idx_d     = sel_idx_q;
    sel_payload_d = sel_payload_q;
    sel_context_d = sel_context_q;
    discard_d     = discard_q;
    n_issued_d    = n_issued_q;
    grant         = '0;
    wb_valid      = 1'b0;
    case (state_q)
      DSP_IDLE: begin
        if (pick_found) begin
          sel_idx_d     = pick_idx;
          sel_payload_d = req_payload[pick_idx*W_PAYLOAD +: W_PAYLOAD];
          sel_context_d = req_context[pick_idx*LEN_CONTEXT +: LEN_CONTEXT];
          discard_d     = 1'b0;
          state_d       = DSP_ORDER;
        end else begin
          state_d = DSP_IDLE;
        end
      end
      DSP_ORDER: begin
        if (exec_accepted) begin
          // Accept beats a same-cycle flush; the flush only poisons write-back.
          grant[sel_idx_q] = 1'b1;
          ptr_d            = sel_idx_q;
          n_issued_d       = (n_issued_q == 16'hFFFF) ? n_issued_q : n_issued_q + 16'd1;
          discard_d        = kill;
          if (exec_done) begin
            wb_valid = ~kill;
            state_d  = DSP_IDLE;
          end else begin
            state_d = DSP_WAIT;
          end
        end else if (kill) begin
          state_d = DSP_IDLE;
        end else begin
          state_d = DSP_ORDER;
        end
      end
      DSP_WAIT: begin
        if (exec_done) begin
          wb_valid = ~(discard_q | kill);
          state_d  = DSP_IDLE;
        end else if (kill) begin
          discard_d = 1'b1;
        end else begin
          state_d = DSP_WAIT;
        end
      end
      default: begin
        state_d = DSP_IDLE;
      end
    endcase
  end

  // State and latched issue bundle; ptr resets to the last slot so slot 0 goes first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= DSP_IDLE;
      ptr_q         <= IW'(N_SLOT - 1);
      sel_idx_q     <= '0;
      sel_payload_q <= '0;
      sel_context_q <= '0;
      discard_q     <= 1'b0;
      n_issued_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_idx_q     <= sel_idx_d;
      sel_payload_q <= sel_payload_d;
      sel_context_q <= sel_context_d;
      discard_q     <= discard_d;
      n_issued_q    <= n_issued_d;
    end
  end

  assign exec_order   = (state_q == DSP_ORDER);
  assign busy         = (state_q != DSP_IDLE);
  assign exec_payload = sel_payload_q;
  assign exec_context = sel_context_q;
  assign n_issued     = n_issued_q;

endmodule

// File: tb/tb_exec_dispatch.sv
// Table-driven bench for exec_dispatch with a payload/context scoreboard
// that is filled at selection time and drained on each grant.
module tb_exec_dispatch;
  import exec_dispatch_pkg::*;

  localparam int NS = 4;
  localparam int WP = 128;

  logic                    clk;
  logic                    rstn;
  logic [NS-1:0]           req;
  logic [NS*WP-1:0]        req_payload;
  logic [NS*LEN_CONTEXT-1:0] req_context;
  logic [NS-1:0]           grant;
  logic                    exec_order;
  logic [WP-1:0]           exec_payload;
  logic [LEN_CONTEXT-1:0]  exec_context;
  logic                    exec_accepted;
  logic                    exec_done;
  logic                    flush;
  logic [LEN_CONTEXT-1:0]  flush_context;
  logic                    wb_valid;
  logic                    busy;
  logic [15:0]             n_issued;

  exec_dispatch #(.N_SLOT(NS), .W_PAYLOAD(WP)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req           (req),
    .req_payload   (req_payload),
    .req_context   (req_context),
    .grant         (grant),
    .exec_order    (exec_order),
    .exec_payload  (exec_payload),
    .exec_context  (exec_context),
    .exec_accepted (exec_accepted),
    .exec_done     (exec_done),
    .flush         (flush),
    .flush_context (flush_context),
    .wb_valid      (wb_valid),
    .busy          (busy),
    .n_issued      (n_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic       flush;
    logic [2:0] fctx;
    logic       acc;
    logic       done;
    int         sel;
    logic       order;
    logic [3:0] grant;
    logic       wb;
    logic       busy;
    int         n;
  } vec_t;

  typedef struct {
    logic [WP-1:0]          p;
    logic [LEN_CONTEXT-1:0] c;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gen    = 0;

  function automatic logic [WP-1:0] pay(input int slot, input int g);
    logic [31:0] w;
    w = {g[23:0], slot[7:0]};
    return {4{w}};
  endfunction

  task automatic add(input logic rs, input logic [3:0] rq, input logic fl, input logic [2:0] fc,
                     input logic ac, input logic dn, input int sl, input logic eo,
                     input logic [3:0] eg, input logic ew, input logic eb, input int en);
    vec_t v;
    v.rstn = rs; v.req = rq; v.flush = fl; v.fctx = fc; v.acc = ac; v.done = dn;
    v.sel = sl; v.order = eo; v.grant = eg; v.wb = ew; v.busy = eb; v.n = en;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic [3:0] rq, input logic fl, input logic [2:0] fc,
                       input logic ac, input logic dn);
    rstn = rs; req = rq; flush = fl; flush_context = fc; exec_accepted = ac; exec_done = dn;
    for (int i = 0; i < NS; i++) req_payload[i*WP +: WP] = pay(i, gen);
  endtask

  // On every grant, the issued bundle must be the one latched at selection.
  task automatic sb_check(input int row);
    exp_t e;
    if (grant !== 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty row %0d: got grant %0h expected no grant", row, grant);
      end else begin
        e = sb.pop_front();
        chk("sb_payload", row, 128'(exec_payload), 128'(e.p));
        chk("sb_context", row, 128'(exec_context), 128'(e.c));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) req_context[i*LEN_CONTEXT +: LEN_CONTEXT] = LEN_CONTEXT'(i);
    req_payload = '0;
    drive(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);

    //  rstn req     fl fctx  acc  done sel eo  grant   wb  busy n
    add(0, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0100, 0, 3'd0, 0, 0,  2, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0100, 0, 3'd0, 1, 1, -1, 1, 4'b0100, 1, 1, 0);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 0, 3'd0, 1, 1,  0, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 0, 3'd0, 1, 1, -1, 1, 4'b0001, 1, 1, 0);
    add(1, 4'b1111, 0, 3'd0, 1, 1,  1, 0, 4'b0000, 0, 0, 1);
    add(1, 4'b1111, 0, 3'd0, 1, 1, -1, 1, 4'b0010, 1, 1, 1);
    add(1, 4'b1111, 0, 3'd0, 1, 1,  2, 0, 4'b0000, 0, 0, 2);
    add(1, 4'b1111, 0, 3'd0, 1, 1, -1, 1, 4'b0100, 1, 1, 2);
    add(1, 4'b1111, 0, 3'd0, 1, 1,  3, 0, 4'b0000, 0, 0, 3);
    add(1, 4'b1111, 0, 3'd0, 1, 1, -1, 1, 4'b1000, 1, 1, 3);
    add(1, 4'b1111, 0, 3'd0, 1, 1,  0, 0, 4'b0000, 0, 0, 4);
    add(1, 4'b1111, 0, 3'd0, 1, 1, -1, 1, 4'b0001, 1, 1, 4);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 5);
    // slow exec: accepted after 3 extra cycles, done 5 cycles later
    add(1, 4'b0010, 0, 3'd0, 0, 0,  1, 0, 4'b0000, 0, 0, 5);
    add(1, 4'b0010, 0, 3'd0, 0, 0, -1, 1, 4'b0000, 0, 1, 5);
    add(1, 4'b0010, 0, 3'd0, 0, 0, -1, 1, 4'b0000, 0, 1, 5);
    add(1, 4'b0010, 0, 3'd0, 0, 0, -1, 1, 4'b0000, 0, 1, 5);
    add(1, 4'b0010, 0, 3'd0, 1, 0, -1, 1, 4'b0010, 0, 1, 5);
    for (int i = 0; i < 4; i++) add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 1, 6);
    add(1, 4'b0000, 0, 3'd0, 0, 1, -1, 0, 4'b0000, 1, 1, 6);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 6);
    // flush in WAIT: matching context discards, non-matching does not
    add(1, 4'b0100, 0, 3'd0, 0, 0,  2, 0, 4'b0000, 0, 0, 6);
    add(1, 4'b0100, 0, 3'd0, 1, 0, -1, 1, 4'b0100, 0, 1, 6);
    add(1, 4'b0000, 1, 3'd2, 0, 0, -1, 0, 4'b0000, 0, 1, 7);
    add(1, 4'b0000, 0, 3'd0, 0, 1, -1, 0, 4'b0000, 0, 1, 7);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 7);
    add(1, 4'b0100, 0, 3'd0, 0, 0,  2, 0, 4'b0000, 0, 0, 7);
    add(1, 4'b0100, 0, 3'd0, 1, 0, -1, 1, 4'b0100, 0, 1, 7);
    add(1, 4'b0000, 1, 3'd1, 0, 0, -1, 0, 4'b0000, 0, 1, 8);
    add(1, 4'b0000, 0, 3'd0, 0, 1, -1, 0, 4'b0000, 1, 1, 8);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 8);
    // flush in IDLE masks the slot; flush in ORDER aborts; slot reissued
    add(1, 4'b1000, 1, 3'd3, 0, 0, -1, 0, 4'b0000, 0, 0, 8);
    add(1, 4'b1000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 8);
    add(1, 4'b1000, 1, 3'd3, 0, 0, -1, 1, 4'b0000, 0, 1, 8);
    add(1, 4'b1000, 0, 3'd0, 0, 0,  3, 0, 4'b0000, 0, 0, 8);
    add(1, 4'b1000, 0, 3'd0, 1, 1, -1, 1, 4'b1000, 1, 1, 8);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 9);
    // accepted and matching flush together: grant fires, write-back killed
    add(1, 4'b0001, 0, 3'd0, 0, 0,  0, 0, 4'b0000, 0, 0, 9);
    add(1, 4'b0001, 1, 3'd0, 1, 1, -1, 1, 4'b0001, 0, 1, 9);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 10);
    add(1, 4'b0010, 0, 3'd0, 0, 0,  1, 0, 4'b0000, 0, 0, 10);
    add(1, 4'b0010, 1, 3'd1, 1, 0, -1, 1, 4'b0010, 0, 1, 10);
    add(1, 4'b0000, 0, 3'd0, 0, 1, -1, 0, 4'b0000, 0, 1, 11);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 11);
    // reset in WAIT, then slot 0 beats slot 3
    add(1, 4'b0100, 0, 3'd0, 0, 0,  2, 0, 4'b0000, 0, 0, 11);
    add(1, 4'b0100, 0, 3'd0, 1, 0, -1, 1, 4'b0100, 0, 1, 11);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 1, 12);
    add(0, 4'b0000, 0, 3'd0, 0, 1, -1, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b1001, 0, 3'd0, 0, 0,  0, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b1001, 0, 3'd0, 1, 1, -1, 1, 4'b0001, 1, 1, 0);
    add(1, 4'b0000, 0, 3'd0, 0, 0, -1, 0, 4'b0000, 0, 0, 1);

    foreach (vecs[k]) begin
      gen = k;
      drive(vecs[k].rstn, vecs[k].req, vecs[k].flush, vecs[k].fctx, vecs[k].acc, vecs[k].done);
      if (vecs[k].sel >= 0) begin
        sb.push_back('{p: pay(vecs[k].sel, gen), c: LEN_CONTEXT'(vecs[k].sel)});
      end
      @(negedge clk);
      chk("order", k, 128'(exec_order), 128'(vecs[k].order));
      chk("grant", k, 128'(grant), 128'(vecs[k].grant));
      chk("wb_valid", k, 128'(wb_valid), 128'(vecs[k].wb));
      chk("busy", k, 128'(busy), 128'(vecs[k].busy));
      chk("n_issued", k, 128'(n_issued), 128'(vecs[k].n));
      if (!vecs[k].rstn) begin
        chk("rst_payload", k, 128'(exec_payload), 128'(0));
        chk("rst_context", k, 128'(exec_context), 128'(0));
      end
      sb_check(k);
      @(posedge clk);
      #1;
    end

    // exec_order holds indefinitely without accepted
    gen = 1000;
    drive(1'b1, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0);
    sb.push_back('{p: pay(1, gen), c: LEN_CONTEXT'(1)});
    @(negedge clk);
    chk("hold_sel_order", 1000, 128'(exec_order), 128'(0));
    @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      gen = 1001 + c;
      drive(1'b1, 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("hold_order", 1001 + c, 128'(exec_order), 128'(1));
      chk("hold_grant", 1001 + c, 128'(grant), 128'(0));
      @(posedge clk);
      #1;
    end
    drive(1'b1, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("hold_grant_end", 1100, 128'(grant), 128'(4'b0010));
    chk("hold_wb", 1100, 128'(wb_valid), 128'(1));
    sb_check(1100);
    @(posedge clk);
    #1;
    // done while idle is ignored
    drive(1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("idle_done_wb", 1101, 128'(wb_valid), 128'(0));
    chk("idle_done_busy", 1101, 128'(busy), 128'(0));
    chk("final_n_issued", 1101, 128'(n_issued), 128'(2));
    chk("sb_drained", 1101, 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
